// File: rtl/usb_pkg.sv
// usb_pkg: shared USB TX types, line-state constants and the NRZI helper.
package usb_pkg;
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SYNC,
        ST_DATA,
        ST_STUFF,
        ST_EOP_SE0,
        ST_EOP_J
    } tx_state_t;

    localparam logic [7:0] SYNC_BYTE    = 8'h80;
    localparam int         STUFF_LIMIT  = 6;
    localparam int         EOP_SE0_BITS = 2;

    // {D+, D-}
    localparam logic [1:0] LINE_J   = 2'b10;
    localparam logic [1:0] LINE_K   = 2'b01;
    localparam logic [1:0] LINE_SE0 = 2'b00;

    function automatic logic [1:0] nrzi(input logic [1:0] cur, input logic b);
        return b ? cur : ~cur;
    endfunction
endpackage

// File: rtl/usb_bit_timer.sv
// usb_bit_timer: divides clk into bus bit periods; bit_strobe marks the last cycle of each period.
module usb_bit_timer #(
    parameter int CLKS_PER_BIT = 8
) (
    input  logic clk,
    input  logic n_rst,
    input  logic run,
    output logic bit_strobe
);
    localparam int CW = $clog2(CLKS_PER_BIT);

    logic [CW-1:0] cnt;

    assign bit_strobe = run && (cnt == CW'(CLKS_PER_BIT - 1));

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst)
            cnt <= '0;
        else
            cnt <= (!run || bit_strobe) ? '0 : cnt + 1'b1;
    end
endmodule

// File: rtl/usb_tx_encoder.sv
// usb_tx_encoder: full-speed USB TX serialiser with bit stuffing, NRZI and EOP.
// Define USB_TX_SYNC_EN to have the block emit the SYNC byte itself ahead of the first accepted byte.
module usb_tx_encoder
    import usb_pkg::*;
#(
    parameter int CLKS_PER_BIT = 8
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    input  logic       tx_last,
    output logic       tx_ready,
    output logic       busy,
    output logic       tx_done,
    output logic       tx_underrun,
    output logic       Dplus_out,
    output logic       Dminus_out
);
    tx_state_t  state;
    logic [7:0] shreg;
    logic [7:0] nxt_byte;
    logic [2:0] bit_idx;
    logic [2:0] ones_cnt;
    logic [1:0] eop_cnt;
    logic [1:0] line;
    logic       last;
    logic       in_sync;
    logic       bit_strobe;
    logic       stuff_due;
    logic       byte_end;
    logic       refill;
    logic       load_byte;
    logic       nxt_bit;

    usb_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
        .clk        (clk),
        .n_rst      (n_rst),
        .run        (busy),
        .bit_strobe (bit_strobe)
    );

`ifdef USB_TX_SYNC_EN
    logic [7:0] held;
    assign nxt_byte = in_sync ? held : tx_data;
`else
    assign in_sync  = 1'b0;
    assign nxt_byte = tx_data;
`endif

    assign busy        = state != ST_IDLE;
    assign stuff_due   = ones_cnt == 3'(STUFF_LIMIT);
    assign nxt_bit     = shreg[bit_idx + 3'd1];
    // A byte ends on bit 7's strobe, or on the following stuff bit's strobe if one is owed.
    assign byte_end    = bit_strobe && bit_idx == 3'd7 &&
                         (state == ST_STUFF || ((state == ST_SYNC || state == ST_DATA) && !stuff_due));
    assign refill      = byte_end && !last && !in_sync;
    assign load_byte   = in_sync || (!last && tx_valid);
    assign tx_ready    = n_rst && (state == ST_IDLE || refill);
    assign tx_underrun = refill && !tx_valid;
    assign tx_done     = bit_strobe && state == ST_EOP_J;
    assign Dplus_out   = line[1];
    assign Dminus_out  = line[0];

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state    <= ST_IDLE;
            shreg    <= '0;
            bit_idx  <= '0;
            ones_cnt <= '0;
            eop_cnt  <= '0;
            last     <= 1'b0;
            line     <= LINE_J;
`ifdef USB_TX_SYNC_EN
            in_sync  <= 1'b0;
            held     <= '0;
`endif
        end else if (state == ST_IDLE) begin
            if (tx_valid) begin
                bit_idx <= '0;
                last    <= tx_last;
`ifdef USB_TX_SYNC_EN
                state    <= ST_SYNC;
                shreg    <= SYNC_BYTE;
                held     <= tx_data;
                in_sync  <= 1'b1;
                line     <= nrzi(line, SYNC_BYTE[0]);
                ones_cnt <= {2'b00, SYNC_BYTE[0]};
`else
                state    <= ST_DATA;
                shreg    <= tx_data;
                line     <= nrzi(line, tx_data[0]);
                ones_cnt <= {2'b00, tx_data[0]};
`endif
            end
        end else if (bit_strobe) begin
            case (state)
                ST_SYNC, ST_DATA, ST_STUFF: begin
                    if (state != ST_STUFF && stuff_due) begin
                        state    <= ST_STUFF;
                        line     <= ~line;
                        ones_cnt <= '0;
                    end else if (bit_idx != 3'd7) begin
                        state    <= state == ST_STUFF ? (in_sync ? ST_SYNC : ST_DATA) : state;
                        bit_idx  <= bit_idx + 3'd1;
                        line     <= nrzi(line, nxt_bit);
                        ones_cnt <= nxt_bit ? ones_cnt + 3'd1 : 3'd0;
                    end else if (load_byte) begin
                        state    <= ST_DATA;
                        shreg    <= nxt_byte;
                        bit_idx  <= '0;
                        last     <= in_sync ? last : tx_last;
                        line     <= nrzi(line, nxt_byte[0]);
                        ones_cnt <= nxt_byte[0] ? ones_cnt + 3'd1 : 3'd0;
`ifdef USB_TX_SYNC_EN
                        in_sync  <= 1'b0;
`endif
                    end else begin
                        state   <= ST_EOP_SE0;
                        line    <= LINE_SE0;
                        eop_cnt <= '0;
                    end
                end
                ST_EOP_SE0: begin
                    if (eop_cnt == 2'(EOP_SE0_BITS - 1)) begin
                        state <= ST_EOP_J;
                        line  <= LINE_J;
                    end else begin
                        eop_cnt <= eop_cnt + 2'd1;
                    end
                end
                ST_EOP_J: state <= ST_IDLE;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_usb_tx_encoder.sv
// tb_usb_tx_encoder: randomized and directed packets checked cycle-by-cycle against a bit-level line model.
// The bench supplies the 8'h80 SYNC byte itself unless USB_TX_SYNC_EN is defined.
module tb_usb_tx_encoder;
    localparam int CPB = 8;

    typedef logic [7:0] bq_t[$];
    typedef struct packed {
        logic dp;
        logic dm;
        logic done;
        logic und;
    } samp_t;
    typedef samp_t sq_t[$];

    logic       clk = 1'b0;
    logic       n_rst = 1'b0;
    logic       tx_valid = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_last = 1'b0;
    logic       tx_ready, busy, tx_done, tx_underrun, Dplus_out, Dminus_out;

    int    total = 0;
    int    bad = 0;
    int    cyc = 0;
    int    start_cyc = 0;
    int    done_seen = 0;
    int    und_seen = 0;
    sq_t   expq;
    samp_t ce;
    logic  cact;

    usb_tx_encoder #(.CLKS_PER_BIT(CPB)) dut (
        .clk         (clk),
        .n_rst       (n_rst),
        .tx_valid    (tx_valid),
        .tx_data     (tx_data),
        .tx_last     (tx_last),
        .tx_ready    (tx_ready),
        .busy        (busy),
        .tx_done     (tx_done),
        .tx_underrun (tx_underrun),
        .Dplus_out   (Dplus_out),
        .Dminus_out  (Dminus_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h @%0t", nm, act, exp, $time);
        end
    endtask

    // Expected per-cycle line samples from the first cycle after the first accept.
    function automatic sq_t model(input bq_t pl, input bit und);
        bq_t  bytes;
        bit   bits[$];
        sq_t  q;
        int   ones;
        logic lvl;
        bytes = pl;
        bytes.push_front(8'h80);
        ones = 0;
        for (int i = 0; i < bytes.size(); i++)
            for (int j = 0; j < 8; j++) begin
                bits.push_back(bytes[i][j]);
                ones = bytes[i][j] ? ones + 1 : 0;
                if (ones == 6) begin
                    bits.push_back(1'b0);
                    ones = 0;
                end
            end
        lvl = 1'b1;
        for (int k = 0; k < bits.size(); k++) begin
            if (!bits[k]) lvl = ~lvl;
            for (int r = 0; r < CPB; r++)
                q.push_back('{lvl, ~lvl, 1'b0, und && k == bits.size() - 1 && r == CPB - 1});
        end
        for (int r = 0; r < 2 * CPB; r++) q.push_back('{1'b0, 1'b0, 1'b0, 1'b0});
        for (int r = 0; r < CPB; r++) q.push_back('{1'b1, 1'b0, r == CPB - 1, 1'b0});
        return q;
    endfunction

    always @(negedge clk) begin
        cact = expq.size() != 0;
        ce = cact ? expq.pop_front() : '{1'b1, 1'b0, 1'b0, 1'b0};
        check("dplus", Dplus_out, ce.dp);
        check("dminus", Dminus_out, ce.dm);
        check("busy", busy, cact);
        check("tx_done", tx_done, ce.done);
        check("tx_underrun", tx_underrun, ce.und);
        done_seen += int'(tx_done);
        und_seen += int'(tx_underrun);
    end

    task automatic send(input bq_t pl, input bit und);
        bq_t drv;
        sq_t sq;
        int  w;
        sq = model(pl, und);
        drv = pl;
`ifndef USB_TX_SYNC_EN
        drv.push_front(8'h80);
`endif
        for (int i = 0; i < drv.size(); i++) begin
            tx_valid = 1'b1;
            tx_data = drv[i];
            tx_last = (i == drv.size() - 1) && !und;
            w = 0;
            do begin
                @(negedge clk);
                w++;
            end while (!tx_ready && w < 3000);
            check("accept", tx_ready, 1);
            if (!tx_ready) break;
            @(posedge clk);
            #1;
            if (i == 0) begin
                expq = sq;
                start_cyc = cyc;
            end
        end
        tx_valid = 1'b0;
        tx_last = 1'b0;
    endtask

    task automatic wait_idle();
        int w;
        w = 0;
        while (expq.size() != 0 && w < 6000) begin
            @(posedge clk);
            #1;
            w++;
        end
        check("drain", expq.size(), 0);
        expq.delete();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: run did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bq_t  pl;
        sq_t  mq;
        logic [15:0] pat;
        logic [8:0]  pat9;
        int   d0, u0, n;

        // Pin the model against hand-derived line sequences.
        pl = {8'h00};
        mq = model(pl, 1'b0);
        check("pin_len_00", mq.size(), 152);
        for (int k = 0; k < 16; k++) pat[15-k] = mq[k*CPB+CPB/2].dp;
        check("pin_nrzi_00", pat, 16'b0101_0100_1010_1010);
        check("pin_se0_00", {mq[16*CPB+4].dp, mq[16*CPB+4].dm}, 2'b00);
        pl = {8'hFF};
        mq = model(pl, 1'b0);
        check("pin_len_ff", mq.size(), 160);
        for (int k = 0; k < 9; k++) pat9[8-k] = mq[(8+k)*CPB+CPB/2].dp;
        check("pin_stuff_ff", pat9, 9'b000001111);
        pl = {8'h3F, 8'h01};
        mq = model(pl, 1'b0);
        check("pin_len_3f01", mq.size(), 224);

        #3;
        check("rst_ready", tx_ready, 0);
        #19 n_rst = 1'b1;
        repeat (100) @(posedge clk);
        #1;

        pl = {8'h00};
        d0 = done_seen;
        send(pl, 1'b0);
        wait_idle();
        check("done_cnt_00", done_seen - d0, 1);

        pl = {8'hFF};
        send(pl, 1'b0);
        wait_idle();

        pl = {8'h3F, 8'h01};
        send(pl, 1'b0);
        wait_idle();

        pl = {8'hA5};
        d0 = done_seen;
        u0 = und_seen;
        send(pl, 1'b1);
        wait_idle();
        check("und_cnt", und_seen - u0, 1);
        check("done_cnt_und", done_seen - d0, 1);

        pl = {8'h55};
        d0 = done_seen;
        send(pl, 1'b0);
        while (cyc < start_cyc + 92) begin
            @(posedge clk);
            #1;
        end
        #1;
        n_rst = 1'b0;
        expq.delete();
        #1;
        check("rst_mid_dp", Dplus_out, 1);
        check("rst_mid_dm", Dminus_out, 0);
        check("rst_mid_busy", busy, 0);
        repeat (3) @(posedge clk);
        #2 n_rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_no_done", done_seen - d0, 0);

        for (int p = 0; p < 20; p++) begin
            pl.delete();
            n = $urandom_range(1, 3);
            for (int b = 0; b < n; b++)
                case ($urandom_range(0, 4))
                    0: pl.push_back(8'hFF);
                    1: pl.push_back(8'h3F);
                    2: pl.push_back(8'h7E);
                    default: pl.push_back(8'($urandom));
                endcase
            send(pl, $urandom_range(0, 3) == 0);
            wait_idle();
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
